// File: rtl/lcd_text_ctrl.sv
// Text-mode DE/RGB565 LCD controller: text RAM -> font ROM -> glyph serialiser.
// Define LCD_TEXT_CURSOR_EN to add a blinking block cursor (cursor_col/cursor_row).
module lcd_text_ctrl #(
  parameter int          H_ACTIVE   = 480,
  parameter int          H_BLANK    = 51,
  parameter int          V_ACTIVE   = 272,
  parameter int          V_BLANK    = 20,
  parameter int          CHAR_W     = 8,
  parameter int          CHAR_H     = 16,
  parameter int          ADDR_W     = 13,
  parameter int          TEXT_DEPTH = 8192,
  parameter int          RAM_LAT    = 2,
  parameter logic [15:0] FG_COLOR   = 16'hFFFF,
  parameter logic [15:0] BG_COLOR   = 16'h0000,
  localparam int         ROW_W      = $clog2(CHAR_H)
) (
  input  logic                  PixelClk,
  input  logic                  rst,
  output logic                  text_rd_en,
  output logic [ADDR_W-1:0]     text_addr,
  input  logic [7:0]            text_data,
  output logic                  font_rd_en,
  output logic [8+ROW_W-1:0]    font_addr,
  input  logic [CHAR_W-1:0]     font_data,
`ifdef LCD_TEXT_CURSOR_EN
  input  logic [7:0]            cursor_col,
  input  logic [7:0]            cursor_row,
`endif
  output logic                  frame_start,
  output logic                  LCD_DE,
  output logic [4:0]            LCD_R,
  output logic [5:0]            LCD_G,
  output logic [4:0]            LCD_B
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int COLS    = H_ACTIVE / CHAR_W;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PD      = 2 * RAM_LAT;
  localparam int AW1     = ADDR_W + 1;
  localparam logic [AW1-1:0] DEPTH = AW1'(TEXT_DEPTH);

  logic [HW-1:0]     h, col;
  logic [VW-1:0]     v;
  logic [AW1-1:0]    row_base, cell_addr;
  logic              active, cell_start, in_range, fetch;
  logic [PD-1:0]     de_pipe, load_pipe, inr_pipe;
  logic [CHAR_W-1:0] shreg, bits;
  logic [15:0]       rgb;
  logic              swap, pix_on;

  always_comb begin
    col        = h / HW'(CHAR_W);
    cell_addr  = row_base + AW1'(col);
    active     = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    cell_start = (h % HW'(CHAR_W)) == '0;
    in_range   = cell_addr < DEPTH;
    fetch      = active && cell_start && in_range;
  end

  // Reads and frame_start are decoded straight from the counters, so they are
  // gated by rst to stay quiet while the counters sit at their reset position.
  assign text_rd_en  = fetch & ~rst;
  assign text_addr   = cell_addr[ADDR_W-1:0];
  assign frame_start = ~rst & (h == '0) & (v == '0);
  assign font_rd_en  = load_pipe[RAM_LAT-1];
  assign font_addr   = font_rd_en ? {text_data, v[ROW_W-1:0]} : '0;

  always_ff @(posedge PixelClk) begin
    if (rst) begin
      h        <= '0;
      v        <= '0;
      row_base <= '0;
    end else if (h == HW'(H_TOTAL - 1)) begin
      h <= '0;
      if (v == VW'(V_TOTAL - 1)) begin
        v        <= '0;
        row_base <= '0;
      end else begin
        v <= v + 1'b1;
        if (v[ROW_W-1:0] == ROW_W'(CHAR_H - 1))
          row_base <= row_base + AW1'(COLS);
      end
    end else begin
      h <= h + 1'b1;
    end
  end

  // Per-pixel tags travel alongside the two memory latencies so the glyph row
  // and its pixel position arrive at the serialiser together.
  always_ff @(posedge PixelClk) begin
    if (rst) begin
      de_pipe   <= '0;
      load_pipe <= '0;
      inr_pipe  <= '0;
    end else begin
      de_pipe   <= {de_pipe[PD-2:0], active};
      load_pipe <= {load_pipe[PD-2:0], fetch};
      inr_pipe  <= {inr_pipe[PD-2:0], in_range};
    end
  end

`ifdef LCD_TEXT_CURSOR_EN
  logic [4:0]    blink;
  logic [PD-1:0] cur_pipe;
  logic          cur_hit;

  assign cur_hit = (8'(col) == cursor_col) && (8'(v / VW'(CHAR_H)) == cursor_row);

  // Advancing on the last counter position means the count changes on the
  // same edge that raises frame_start, so frame N shows count N.
  always_ff @(posedge PixelClk) begin
    if (rst) begin
      blink    <= '0;
      cur_pipe <= '0;
    end else begin
      if (h == HW'(H_TOTAL - 1) && v == VW'(V_TOTAL - 1))
        blink <= blink + 1'b1;
      cur_pipe <= {cur_pipe[PD-2:0], cur_hit};
    end
  end

  assign swap = blink[4] & cur_pipe[PD-1];
`else
  assign swap = 1'b0;
`endif

  // The first pixel of a cell bypasses the shift register straight from font_data.
  always_comb begin
    bits   = load_pipe[PD-1] ? font_data : shreg;
    pix_on = (bits[CHAR_W-1] & inr_pipe[PD-1]) ^ swap;
  end

  always_ff @(posedge PixelClk) begin
    if (rst) begin
      shreg  <= '0;
      LCD_DE <= 1'b0;
      rgb    <= '0;
    end else begin
      shreg  <= bits << 1;
      LCD_DE <= de_pipe[PD-1];
      rgb    <= de_pipe[PD-1] ? (pix_on ? FG_COLOR : BG_COLOR) : '0;
    end
  end

  assign LCD_R = rgb[15:11];
  assign LCD_G = rgb[10:5];
  assign LCD_B = rgb[4:0];

endmodule
